arbitro_desplazador: RTL and testbench

Shares the single 10-bit right-shift unit of the ALU between two requesters, with round-robin arbitration.
- Registers the winning operand and shift amount, drives them to the external combinational shifter, and captures the shifted word.
- Returns the result through a valid/ready handshake tagged with the requester ID.
- Counts completed operations.

---
 rtl/arbitro_desplazador_if.sv | 59 +++++
 rtl/arbitro_desplazador.sv | 161 ++++++++++++++++
 tb/tb_arbitro_desplazador.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_desplazador_if.sv
//-----------------------------------------------------------------------------
// arbitro_desplazador_if
// Bundles every signal between the shift-unit arbiter and its environment.
// The environment is the two requesters, the external shifter and the result
// consumer.
//   req0_* / req1_* : valid/ready request channels (operand + shift amount)
//   sh_in / sh_amt  : registered operand and amount driven to the shifter
//   sh_out          : combinational result returned by the shifter
//   res_*           : valid/ready result channel tagged with requester id
//   op_count        : delivered-operation counter (wraps)
// Modport 'slave' is the arbiter side; 'master' is the environment side.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface arbitro_desplazador_if #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4,
    parameter int CW    = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_shift;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_shift;
    logic             req1_ready;
    logic [WIDTH-1:0] sh_in;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_out;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ready;
    logic [CW-1:0]    op_count;

    modport slave (
        input  req0_valid, req0_data, req0_shift,
        output req0_ready,
        input  req1_valid, req1_data, req1_shift,
        output req1_ready,
        output sh_in, sh_amt,
        input  sh_out,
        output res_valid, res_data, res_id,
        input  res_ready,
        output op_count
    );

    modport master (
        output req0_valid, req0_data, req0_shift,
        input  req0_ready,
        output req1_valid, req1_data, req1_shift,
        input  req1_ready,
        input  sh_in, sh_amt,
        output sh_out,
        input  res_valid, res_data, res_id,
        output res_ready,
        input  op_count
    );
endinterface

// File: rtl/arbitro_desplazador.sv
//-----------------------------------------------------------------------------
// arbitro_desplazador
// Shares one external combinational right-shift unit between two requesters
// using round-robin arbitration. The winning operand and amount are
// registered onto the shifter inputs. The shifted word is captured one cycle
// later and then offered on a valid/ready result channel tagged with the
// requester id. Delivered operations are counted modulo 2^CW.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arbitro_desplazador_if.slave (requests, shifter, result, count)
// Sequence per operation: IDLE (accept) -> DESPLAZA (capture) -> ENTREGA
// (deliver), giving at most one operation every three cycles.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module arbitro_desplazador #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arbitro_desplazador_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DESPLAZA = 2'd1,
        ENTREGA  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;       // requester granted most recently
    logic             grant0_s;
    logic             grant1_s;
    logic [WIDTH-1:0] sh_in_r;
    logic [SHW-1:0]   sh_amt_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_id_r;
    logic             res_valid_r;
    logic [CW-1:0]    op_count_r;

    // Round-robin grant: only in IDLE, and on contention the requester that
    // was not served last wins, so at most one grant is ever high.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Ready is the grant itself; it is forced low while reset is asserted so
    // nothing looks accepted while the state is being cleared.
    assign bus.req0_ready = grant0_s & rst_n;
    assign bus.req1_ready = grant1_s & rst_n;

    // Next-state logic for the accept / shift / deliver sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_nxt_s = DESPLAZA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DESPLAZA: begin
                state_nxt_s = ENTREGA;
            end
            ENTREGA: begin
                if (bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ENTREGA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: latch the winner, capture the shifter output and
    // count deliveries. last_r resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_in_r     <= {WIDTH{1'b0}};
            sh_amt_r    <= {SHW{1'b0}};
            res_data_r  <= {WIDTH{1'b0}};
            res_id_r    <= 1'b0;
            res_valid_r <= 1'b0;
            op_count_r  <= {CW{1'b0}};
            last_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s) begin
                        sh_in_r  <= bus.req0_data;
                        sh_amt_r <= bus.req0_shift;
                        res_id_r <= 1'b0;
                        last_r   <= 1'b0;
                    end else if (grant1_s) begin
                        sh_in_r  <= bus.req1_data;
                        sh_amt_r <= bus.req1_shift;
                        res_id_r <= 1'b1;
                        last_r   <= 1'b1;
                    end
                end
                DESPLAZA: begin
                    res_data_r  <= bus.sh_out;
                    res_valid_r <= 1'b1;
                end
                ENTREGA: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sh_in     = sh_in_r;
    assign bus.sh_amt    = sh_amt_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_valid = res_valid_r;
    assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_arbitro_desplazador.sv
`timescale 1ns/1ps
module tb_arbitro_desplazador;
    localparam int WIDTH = 10;
    localparam int SHW   = 4;
    localparam int CW    = 8;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arbitro_desplazador_if #(.WIDTH(WIDTH), .SHW(SHW), .CW(CW)) bus();

    arbitro_desplazador #(.WIDTH(WIDTH), .SHW(SHW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External shifter: pass-through, logical right shift, zero for >= WIDTH.
    always_comb begin
        if (bus.sh_amt >= 4'd10) bus.sh_out = '0;
        else                     bus.sh_out = bus.sh_in >> bus.sh_amt;
    end

    int checks = 0;
    int passes = 0;

    exp_t exp_q[$];
    exp_t hist[$];
    int   phase;
    bit   mlast;
    int   mcount;
    bit   e0, e1;
    bit   hs0, hs1, hd;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s);
        int unsigned v;
        v = d;
        if (s >= 4'd10) return '0;
        return WIDTH'(v / (32'd1 << s));
    endfunction

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endtask

    // Monitor / scoreboard: samples at the falling edge.
    initial begin
        exp_t t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                phase  = 0;
                mlast  = 1'b1;
                mcount = 0;
            end else begin
                e0 = (phase == 0) && bus.req0_valid && (!bus.req1_valid || mlast);
                e1 = (phase == 0) && bus.req1_valid && (!bus.req0_valid || !mlast);
                chk("req0_ready", bus.req0_ready === e0, 32'(bus.req0_ready), 32'(e0));
                chk("req1_ready", bus.req1_ready === e1, 32'(bus.req1_ready), 32'(e1));
                chk("res_valid", bus.res_valid === (phase == 2), 32'(bus.res_valid), 32'(phase == 2));
                chk("op_count", bus.op_count === CW'(mcount), 32'(bus.op_count), 32'(CW'(mcount)));
                if (phase == 0) begin
                    if (e0) begin
                        t.id = 1'b0; t.data = ref_shift(bus.req0_data, bus.req0_shift);
                        exp_q.push_back(t); mlast = 1'b0; phase = 1;
                    end else if (e1) begin
                        t.id = 1'b1; t.data = ref_shift(bus.req1_data, bus.req1_shift);
                        exp_q.push_back(t); mlast = 1'b1; phase = 1;
                    end
                end else if (phase == 1) begin
                    phase = 2;
                end else if (exp_q.size() > 0) begin
                    chk("res_data", bus.res_data === exp_q[0].data, 32'(bus.res_data), 32'(exp_q[0].data));
                    chk("res_id", bus.res_id === exp_q[0].id, 32'(bus.res_id), 32'(exp_q[0].id));
                    if (bus.res_ready) begin
                        hist.push_back(exp_q[0]);
                        void'(exp_q.pop_front());
                        mcount++;
                        phase = 0;
                    end
                end
            end
        end
    end

    // One clock: note handshakes at the falling edge, return 1ns after rise.
    task automatic step();
        @(negedge clk);
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        hd  = bus.res_valid && bus.res_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, bus.res_valid === 1'b0, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"}, bus.res_data === '0, 32'(bus.res_data), 32'd0);
        chk({tag, "_res_id"}, bus.res_id === 1'b0, 32'(bus.res_id), 32'd0);
        chk({tag, "_sh_in"}, bus.sh_in === '0, 32'(bus.sh_in), 32'd0);
        chk({tag, "_sh_amt"}, bus.sh_amt === '0, 32'(bus.sh_amt), 32'd0);
        chk({tag, "_op_count"}, bus.op_count === '0, 32'(bus.op_count), 32'd0);
        chk({tag, "_ready"}, {bus.req0_ready, bus.req1_ready} === 2'b00,
            32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk_reset_outputs(tag);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        for (int n = 0; n < 6; n++) step();
    endtask

    task automatic run_op(input bit id, input logic [WIDTH-1:0] d, input logic [SHW-1:0] s);
        bit got;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_shift = s; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_shift = s; end
        bus.res_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = id ? hs1 : hs0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("accept_timeout", got, 32'(got), 32'd1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            got = hd;
        end
        chk("deliver_timeout", got, 32'(got), 32'd1);
    endtask

    task automatic chk_last(input string name, input logic [WIDTH-1:0] d, input logic id);
        exp_t t;
        t = (hist.size() > 0) ? hist[hist.size()-1] : '0;
        chk({name, "_data"}, t.data === d, 32'(t.data), 32'(d));
        chk({name, "_id"}, t.id === id, 32'(t.id), 32'(id));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int opc0;
        int dels;
        int cyc;
        bit a0, a1;
        exp_t t;

        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_shift = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_shift = '0;
        bus.res_ready  = 1'b0;

        // Reset then idle.
        #3;
        chk_reset_outputs("por");
        step(); step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) step();

        // Single requests: plain, zero and overflow shifts.
        run_op(1'b0, 10'h2CE, 4'd3);
        chk_last("sh3", 10'h059, 1'b0);
        chk("sh3_count", bus.op_count === 8'd1, 32'(bus.op_count), 32'd1);
        run_op(1'b0, 10'h2CE, 4'd0);
        chk_last("sh0", 10'h2CE, 1'b0);
        run_op(1'b0, 10'h2CE, 4'd12);
        chk_last("sh12", 10'h000, 1'b0);
        chk("sh12_count", bus.op_count === 8'd3, 32'(bus.op_count), 32'd3);

        // Contention after reset: requester 0 first, then requester 1.
        do_reset("rst_a");
        bus.req0_valid = 1'b1; bus.req0_data = 10'h3FF; bus.req0_shift = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_data = 10'h200; bus.req1_shift = 4'd9;
        bus.res_ready  = 1'b1;
        first = 2;
        for (int n = 0; n < 30 && (bus.req0_valid || bus.req1_valid); n++) begin
            step();
            if (hs0) begin bus.req0_valid = 1'b0; if (first == 2) first = 0; end
            if (hs1) begin bus.req1_valid = 1'b0; if (first == 2) first = 1; end
        end
        drain();
        chk("rr_first", first == 0, 32'(first), 32'd0);
        t = (hist.size() > 1) ? hist[hist.size()-2] : '0;
        chk("rr_a_data", t.data === 10'h1FF, 32'(t.data), 32'h1FF);
        chk("rr_a_id", t.id === 1'b0, 32'(t.id), 32'd0);
        chk_last("rr_b", 10'h001, 1'b1);

        // Both again: requester 0 is next in turn.
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        a0 = 1'b0; a1 = 1'b0;
        for (int n = 0; n < 20 && !(a0 || a1); n++) begin
            step();
            a0 = hs0; a1 = hs1;
        end
        chk("rr_again", a0 && !a1, 32'({a0, a1}), 32'b10);
        drain();

        // Backpressure: result held while requester 1 waits.
        bus.res_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 10'h155; bus.req0_shift = 4'd2;
        a0 = 1'b0;
        for (int n = 0; n < 20 && !a0; n++) begin step(); a0 = hs0; end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 10'h0F0; bus.req1_shift = 4'd4;
        opc0 = int'(bus.op_count);
        for (int n = 0; n < 7; n++) begin
            step();
            chk("bp_no_accept", !hs1, 32'(hs1), 32'd0);
        end
        chk("bp_count_hold", bus.op_count === CW'(opc0), 32'(bus.op_count), 32'(opc0));
        bus.res_ready = 1'b1;
        step();
        chk("bp_deliver", hd, 32'(hd), 32'd1);
        chk("bp_count_inc", bus.op_count === CW'(opc0 + 1), 32'(bus.op_count), 32'(CW'(opc0 + 1)));
        step();
        chk("bp_next_accept", hs1, 32'(hs1), 32'd1);
        drain();

        // Reset while requester 1's operation is in DESPLAZA.
        bus.req1_valid = 1'b1; bus.req1_data = 10'h3C3; bus.req1_shift = 4'd1;
        a1 = 1'b0;
        for (int n = 0; n < 20 && !a1; n++) begin step(); a1 = hs1; end
        #1;
        do_reset("rst_mid");
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_mid_no_valid", bus.res_valid === 1'b0, 32'(bus.res_valid), 32'd0);
        end
        chk("rst_mid_count", bus.op_count === '0, 32'(bus.op_count), 32'd0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("rst_mid_grant", {bus.req0_ready, bus.req1_ready} === 2'b10,
            32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        for (int n = 0; n < 10; n++) begin
            step();
            if (hs0) bus.req0_valid = 1'b0;
            if (hs1) bus.req1_valid = 1'b0;
        end
        drain();

        // Randomized traffic with withdrawals and backpressure.
        for (int c = 0; c < 600; c++) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
            if (!bus.req0_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.req0_valid = 1'b1;
                    bus.req0_data  = WIDTH'($urandom);
                    bus.req0_shift = SHW'($urandom);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.req1_valid = 1'b1;
                    bus.req1_data  = WIDTH'($urandom);
                    bus.req1_shift = SHW'($urandom);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                bus.req1_valid = 1'b0;
            end
            step();
            if (hs0) bus.req0_valid = 1'b0;
            if (hs1) bus.req1_valid = 1'b0;
        end
        drain();

        // Counter wrap: 256 back-to-back operations.
        do_reset("rst_wrap");
        bus.res_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = WIDTH'($urandom);
        bus.req0_shift = SHW'($urandom);
        dels = 0;
        cyc  = 0;
        while (dels < 256 && cyc < 2000) begin
            step();
            cyc++;
            if (hs0) begin
                bus.req0_data  = WIDTH'($urandom);
                bus.req0_shift = SHW'($urandom);
            end
            if (hd) dels++;
        end
        bus.req0_valid = 1'b0;
        chk("wrap_deliveries", dels == 256, 32'(dels), 32'd256);
        chk("wrap_throughput", cyc == 768, 32'(cyc), 32'd768);
        chk("wrap_count", bus.op_count === '0, 32'(bus.op_count), 32'd0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
